// File: rtl/spi_pkg.sv
// Shared constants and FSM encoding for the SPI mode-0 target.
package spi_pkg;
  localparam int WORD_W_DEF = 16;
  localparam int BITS_W     = 5;

  typedef enum logic [1:0] {WAIT_IDLE, IDLE, ACTIVE} state_t;

  localparam logic [WORD_W_DEF-1:0] TX_IDLE_FILL = '1;
endpackage

// File: rtl/spi_target_if.sv
// Host-side streams of the SPI target: TX holding register, RX FIFO head, sticky status.
interface spi_target_if #(parameter int WORD_W = 16);
  logic [WORD_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic [WORD_W-1:0] rx_data;
  logic [4:0]        rx_bits;
  logic              rx_valid;
  logic              rx_ready;
  logic              overrun;
  logic              underrun;
  logic              clr_status;

  modport slave (
    input  tx_data, tx_valid, rx_ready, clr_status,
    output tx_ready, rx_data, rx_bits, rx_valid, overrun, underrun
  );
  modport master (
    output tx_data, tx_valid, rx_ready, clr_status,
    input  tx_ready, rx_data, rx_bits, rx_valid, overrun, underrun
  );
endinterface

// File: rtl/spi_rx_fifo.sv
// Synchronous FIFO for received frames; head reads as zero when empty.
module spi_rx_fifo #(
  parameter int W     = 21,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         wr_en,
  input  logic [W-1:0] wr_data,
  input  logic         rd_en,
  output logic [W-1:0] rd_data,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          wr_ok, rd_ok;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  // A pop frees the slot in the same cycle, so a full FIFO still accepts a push alongside it.
  assign wr_ok = wr_en && (!full || rd_en);
  assign rd_ok = rd_en && !empty;
  assign rd_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + AW'(1);
      if (rd_ok) rd_ptr <= rd_ptr + AW'(1);
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/spi_target.sv
// SPI mode-0 MSB-first target: oversampled pins, frame FSM, TX holding register, RX FIFO.
module spi_target
  import spi_pkg::*;
#(
  parameter int WORD_W   = WORD_W_DEF,
  parameter int RX_DEPTH = 4
) (
  input  logic ACLK,
  input  logic ARESET,
  input  logic in_sck,
  input  logic in_cs,
  input  logic in_si,
  output logic out_so,
  spi_target_if.slave host
);
  logic [1:0] sck_sync, cs_sync, si_sync, settle;
  logic       sck_d, cs_d, sck_s, cs_s, si_s;
  logic       sck_rise, sck_fall, cs_rise, cs_fall;

  state_t state_q, state_d;
  logic   frame_start, frame_end, shift_in, shift_out, push;

  logic [WORD_W-1:0] tx_buf, tx_shift, rx_shift;
  logic              tx_full;
  logic [BITS_W-1:0] bit_cnt;
  logic              fifo_full, fifo_empty;

  assign sck_s    = sck_sync[1];
  assign cs_s     = cs_sync[1];
  assign si_s     = si_sync[1];
  assign sck_rise = sck_s & ~sck_d;
  assign sck_fall = ~sck_s & sck_d;
  assign cs_rise  = cs_s & ~cs_d;
  assign cs_fall  = ~cs_s & cs_d;

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      sck_sync <= 2'b00;
      cs_sync  <= 2'b11;
      si_sync  <= 2'b00;
      sck_d    <= 1'b0;
      cs_d     <= 1'b1;
      settle   <= 2'b00;
    end else begin
      sck_sync <= {sck_sync[0], in_sck};
      cs_sync  <= {cs_sync[0], in_cs};
      si_sync  <= {si_sync[0], in_si};
      sck_d    <= sck_s;
      cs_d     <= cs_s;
      settle   <= {settle[0], 1'b1};
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) state_q <= WAIT_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    frame_start = 1'b0;
    frame_end   = 1'b0;
    shift_in    = 1'b0;
    shift_out   = 1'b0;
    case (state_q)
      // The synchroniser resets to cs high; wait until it has refilled from the pin
      // so a frame already in progress is not mistaken for a fresh cs fall.
      WAIT_IDLE: if (settle[1] && cs_s) state_d = IDLE;
      IDLE: if (cs_fall) begin
        state_d     = ACTIVE;
        frame_start = 1'b1;
      end
      ACTIVE: begin
        if (cs_rise) begin
          state_d   = IDLE;
          frame_end = 1'b1;
        end else begin
          shift_in  = sck_rise;
          shift_out = sck_fall;
        end
      end
      default: state_d = WAIT_IDLE;
    endcase
  end

  assign push   = frame_end && (bit_cnt != '0);
  assign out_so = (state_q == ACTIVE) ? tx_shift[WORD_W-1] : 1'b1;

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      tx_shift <= TX_IDLE_FILL[WORD_W-1:0];
      rx_shift <= '0;
      bit_cnt  <= '0;
    end else if (frame_start) begin
      tx_shift <= tx_full ? tx_buf : TX_IDLE_FILL[WORD_W-1:0];
      rx_shift <= '0;
      bit_cnt  <= '0;
    end else if (shift_in) begin
      rx_shift <= {rx_shift[WORD_W-2:0], si_s};
      if (bit_cnt != BITS_W'(WORD_W)) bit_cnt <= bit_cnt + BITS_W'(1);
    end else if (shift_out) begin
      tx_shift <= {tx_shift[WORD_W-2:0], 1'b1};
    end
  end

  // A write landing with the cs fall (buffer empty) is kept for the following frame.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      tx_full <= 1'b0;
      tx_buf  <= '0;
    end else if (host.tx_valid && !tx_full) begin
      tx_full <= 1'b1;
      tx_buf  <= host.tx_data;
    end else if (frame_start) begin
      tx_full <= 1'b0;
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      host.overrun  <= 1'b0;
      host.underrun <= 1'b0;
    end else begin
      if (push && fifo_full && !host.rx_ready) host.overrun <= 1'b1;
      else if (host.clr_status)                host.overrun <= 1'b0;
      if (frame_start && !tx_full)             host.underrun <= 1'b1;
      else if (host.clr_status)                host.underrun <= 1'b0;
    end
  end

  assign host.tx_ready = !tx_full;
  assign host.rx_valid = !fifo_empty;

  spi_rx_fifo #(.W(WORD_W + BITS_W), .DEPTH(RX_DEPTH)) u_fifo (
    .clk     (ACLK),
    .rst     (ARESET),
    .wr_en   (push),
    .wr_data ({bit_cnt, rx_shift}),
    .rd_en   (host.rx_ready),
    .rd_data ({host.rx_bits, host.rx_data}),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );
endmodule
